// File: rtl/mult2x2_chk_pkg.sv
// mult2x2_chk_pkg: shared state enum, default MISR taps and golden product for the 2x2 response checker
package mult2x2_chk_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  localparam logic [15:0] MISR_POLY_DEF = 16'h100B;

  function automatic logic [3:0] golden(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/mult2x2_misr.sv
// mult2x2_misr: Galois-style MISR compacting one 8-bit word per enabled cycle, with synchronous clear
module mult2x2_misr import mult2x2_chk_pkg::*; #(
  parameter int W = 16,
  parameter logic [W-1:0] POLY = W'(MISR_POLY_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   din,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d;

  assign sig = sig_q;

  // next signature: shift, fold in taps when the MSB falls out, then xor the data word
  always_comb begin
    sig_d = sig_q;
    sig_d = clr ? '0
          : en  ? ({sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0)) ^ W'(din)
          : sig_q;
  end

  // signature register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;

endmodule

// File: rtl/mult2x2_resp_checker.sv
// mult2x2_resp_checker: checks 2x2 multiplier products, counts mismatches, logs first failure, MISR-compacts beats; MULT2X2_COV_EN adds operand-pair coverage
module mult2x2_resp_checker import mult2x2_chk_pkg::*; #(
  parameter int MISR_W = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEF),
  parameter int CNT_W = 8,
  parameter int NUM_PATTERNS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  input  logic [3:0]        q,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              first_fail_valid,
  output logic [7:0]        first_fail_vec,
  output logic [MISR_W-1:0] signature,
  output logic              done,
`ifdef MULT2X2_COV_EN
  output logic [15:0]       cov_map,
  output logic              cov_full,
`endif
  output logic              pass
);

  localparam int BW = $clog2(NUM_PATTERNS + 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic             ffv_q, ffv_d;
  logic [7:0]       ffvec_q, ffvec_d;
  logic             err_q, err_d;
  logic             acc, bad;

  // a start in RUN restarts the session, so the beat presented with it is dropped
  assign in_ready = state_q == RUN;
  assign acc      = in_valid && in_ready && !start;
  assign bad      = q != golden(a, b);

  assign err_pulse        = err_q;
  assign mismatch_cnt     = mis_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign done             = state_q == DONE;

  mult2x2_misr #(.W(MISR_W), .POLY(MISR_POLY)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (acc),
    .din   ({a, b, q}),
    .sig   (signature)
  );

`ifdef MULT2X2_COV_EN
  logic [15:0] cov_q, cov_d;
  assign cov_map  = cov_q;
  assign cov_full = &cov_q;
  assign pass     = done && mis_q == '0 && cov_full;
  // coverage bitmap indexed by {a,b}, cleared when a session opens
  always_comb begin
    cov_d = cov_q;
    cov_d = start ? '0 : acc ? cov_q | (16'd1 << {a, b}) : cov_q;
  end
  // coverage register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cov_q <= '0;
    else        cov_q <= cov_d;
`else
  assign pass = done && mis_q == '0;
`endif

  // next state, beat counter and result bookkeeping; start clears everything on entry to RUN
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    mis_d   = mis_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    err_d   = 1'b0;
    state_d = start ? RUN
            : (acc && beat_q == BW'(NUM_PATTERNS - 1)) ? DONE
            : state_q;
    beat_d  = start ? '0 : acc ? beat_q + 1'b1 : beat_q;
    mis_d   = start ? '0 : (acc && bad && !(&mis_q)) ? mis_q + 1'b1 : mis_q;
    ffv_d   = start ? 1'b0 : ffv_q | (acc && bad);
    ffvec_d = start ? '0 : (acc && bad && !ffv_q) ? {a, b, q} : ffvec_q;
    err_d   = acc && bad;
  end

  // state and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      mis_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mis_q   <= mis_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      err_q   <= err_d;
    end

endmodule

// File: tb/tb_mult2x2_resp_checker.sv
// tb_mult2x2_resp_checker: directed-vector bench for mult2x2_resp_checker (default and CNT_W=2 instances)
module tb_mult2x2_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  a = '0;
  logic [1:0]  b = '0;
  logic [3:0]  q = '0;
  logic        in_ready, err_pulse, ffv, done, pass;
  logic [7:0]  mis, ffvec;
  logic [15:0] sig;
  logic        in_ready2, err_pulse2, ffv2, done2, pass2;
  logic [1:0]  mis2;
  logic [7:0]  ffvec2;
  logic [15:0] sig2;
`ifdef MULT2X2_COV_EN
  logic [15:0] cov_map, cov_map2;
  logic        cov_full, cov_full2;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] msig;

  always #5 clk = ~clk;

  mult2x2_resp_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .q(q), .err_pulse(err_pulse), .mismatch_cnt(mis),
    .first_fail_valid(ffv), .first_fail_vec(ffvec), .signature(sig), .done(done),
`ifdef MULT2X2_COV_EN
    .cov_map(cov_map), .cov_full(cov_full),
`endif
    .pass(pass)
  );

  mult2x2_resp_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .q(q), .err_pulse(err_pulse2), .mismatch_cnt(mis2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .signature(sig2), .done(done2),
`ifdef MULT2X2_COV_EN
    .cov_map(cov_map2), .cov_full(cov_full2),
`endif
    .pass(pass2)
  );

  function automatic logic [15:0] mupd(input logic [15:0] s, input logic [7:0] d);
    return ({s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000)) ^ {8'h00, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic open_session;
    start = 1'b1;
    tick();
    start = 1'b0;
    msig = '0;
  endtask

  task automatic beat(input logic [1:0] ai, input logic [1:0] bi, input logic [3:0] qi);
    in_valid = 1'b1; a = ai; b = bi; q = qi;
    tick();
    in_valid = 1'b0;
    msig = mupd(msig, {ai, bi, qi});
  endtask

  initial begin
    logic [3:0] p;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", sig, 0);
    chk("rst_cnt", mis, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", in_ready, 0);

    // exhaustive clean sweep
    open_session();
    chk("run_ready", in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      p = 4'(i[3:2] * i[1:0]);
      beat(i[3:2], i[1:0], p);
      if (i == 14) chk("clean_done_early", done, 0);
    end
    chk("clean_done", done, 1);
    chk("clean_pass", pass, 1);
    chk("clean_ready_low", in_ready, 0);
    chk("clean_cnt", mis, 0);
    chk("clean_ffv", ffv, 0);
    chk("clean_sig", sig, msig);
    tick();
    chk("clean_hold_sig", sig, msig);

    // trojan: 3*3 returns 1
    open_session();
    chk("trj_cleared_sig", sig, 0);
    for (int i = 0; i < 16; i++) begin
      p = (i == 15) ? 4'h1 : 4'(i[3:2] * i[1:0]);
      beat(i[3:2], i[1:0], p);
      if (i == 14) chk("trj_err_quiet", err_pulse, 0);
    end
    chk("trj_err", err_pulse, 1);
    chk("trj_cnt", mis, 1);
    chk("trj_ffv", ffv, 1);
    chk("trj_vec", ffvec, 8'hF1);
    chk("trj_done", done, 1);
    chk("trj_pass", pass, 0);
    chk("trj_sig", sig, msig);
    tick();
    chk("trj_err_fall", err_pulse, 0);

    // back-pressure 1-0-0-1 with garbage on idle cycles
    open_session();
    for (int i = 0; i < 16; i++) begin
      p = 4'(i[3:2] * i[1:0]);
      beat(i[3:2], i[1:0], p);
      if (i == 14) chk("bp_done_early", done, 0);
      a = 2'd3; b = 2'd3; q = 4'h0;
      if (i != 15) begin
        tick(); tick();
      end
    end
    chk("bp_done", done, 1);
    chk("bp_cnt", mis, 0);
    chk("bp_sig", sig, msig);

    // saturation on the CNT_W=2 instance
    open_session();
    beat(2'd1, 2'd1, 4'h0);
    beat(2'd2, 2'd2, 4'h0);
    beat(2'd3, 2'd1, 4'h0);
    beat(2'd2, 2'd3, 4'h1);
    beat(2'd1, 2'd3, 4'h0);
    chk("sat_cnt2", mis2, 3);
    chk("sat_vec2", ffvec2, 8'h50);
    chk("sat_cnt8", mis, 5);
    chk("sat_vec8", ffvec, 8'h50);

    // restart in RUN with a bad beat presented alongside start
    in_valid = 1'b1; a = 2'd2; b = 2'd2; q = 4'h3;
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    msig = '0;
    chk("rs_cnt", mis, 0);
    chk("rs_ffv", ffv, 0);
    chk("rs_sig", sig, 0);
    chk("rs_err", err_pulse, 0);
    chk("rs_ready", in_ready, 1);
    for (int i = 0; i < 15; i++) beat(2'd1, 2'd2, 4'h2);
    chk("rs_done_15", done, 0);
    beat(2'd2, 2'd1, 4'h2);
    chk("rs_done_16", done, 1);
    chk("rs_pass", pass, 1);
    chk("rs_sig_end", sig, msig);

    // asynchronous reset mid-session
    open_session();
    beat(2'd3, 2'd2, 4'h0);
    beat(2'd1, 2'd1, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt", mis, 0);
    chk("ar_ffv", ffv, 0);
    chk("ar_vec", ffvec, 0);
    chk("ar_sig", sig, 0);
    chk("ar_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    beat(2'd3, 2'd3, 4'h0);
    chk("ar_idle_cnt", mis, 0);
    chk("ar_idle_done", done, 0);
    chk("ar_idle_ready", in_ready, 0);

`ifdef MULT2X2_COV_EN
    open_session();
    for (int i = 0; i < 15; i++) begin
      p = 4'(i[3:2] * i[1:0]);
      beat(i[3:2], i[1:0], p);
    end
    beat(2'd0, 2'd0, 4'h0);
    chk("cov_map", cov_map, 16'h7FFF);
    chk("cov_full", cov_full, 0);
    chk("cov_done", done, 1);
    chk("cov_pass", pass, 0);
    open_session();
    chk("cov_clear", cov_map, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
